// File: rtl/opcode_fetch.sv
// CHIP-8 opcode fetch: reads the big-endian opcode at program_counter in two byte reads and hands it to execute.
// Optional illegal-encoding trap enabled by defining OPCODE_FETCH_ILLEGAL_TRAP_EN.
module opcode_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] program_counter,
  input  logic        flush,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_rdata,
  output logic [11:0] mem_addr,
  output logic        mem_re,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] opcode,
  output logic [15:0] op_pc,
  output logic [3:0]  op_class,
  output logic [3:0]  op_x,
  output logic [3:0]  op_y,
  output logic [3:0]  op_n,
  output logic [7:0]  op_nn,
  output logic [11:0] op_nnn,
  output logic        op_illegal,
  output logic        stalled
);

  typedef enum logic [1:0] {HI_REQ, LO_REQ, LO_WAIT, VALID} state_t;

  state_t      state, state_next;
  logic        hi_first;
  logic [7:0]  hi_byte;
  logic [11:0] lo_addr;
  logic        hi_accept;

  assign lo_addr   = op_pc[11:0] + 12'd1;
  assign hi_accept = (state == HI_REQ) && mem_gnt && !flush;

  always_comb begin
    state_next = state;
    mem_addr   = program_counter[11:0];
    mem_re     = 1'b0;
    case (state)
      HI_REQ: begin
        mem_re = mem_gnt;
        if (mem_gnt) state_next = LO_REQ;
      end
      LO_REQ: begin
        mem_addr = lo_addr;
        mem_re   = mem_gnt;
        if (mem_gnt) state_next = LO_WAIT;
      end
      LO_WAIT: begin
        mem_addr   = lo_addr;
        state_next = VALID;
      end
      VALID: begin
        if (op_ready) state_next = HI_REQ;
      end
      default: state_next = HI_REQ;
    endcase
    if (flush) state_next = HI_REQ;
    if (rst) mem_re = 1'b0;
  end

  // hi_first marks the single cycle in which the high byte sits on mem_rdata,
  // so a grant stall in LO_REQ cannot overwrite it with stale read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HI_REQ;
      hi_first <= 1'b0;
      hi_byte  <= 8'h00;
      opcode   <= 16'h0000;
      op_pc    <= 16'h0000;
    end else begin
      state    <= state_next;
      hi_first <= hi_accept;
      if (hi_accept) op_pc <= program_counter;
      if (state == LO_REQ && hi_first) hi_byte <= mem_rdata;
      if (state == LO_WAIT && !flush) opcode <= {hi_byte, mem_rdata};
    end
  end

  assign op_valid = (state == VALID);
  assign stalled  = !(op_valid && op_ready);
  assign op_class = opcode[15:12];
  assign op_x     = opcode[11:8];
  assign op_y     = opcode[7:4];
  assign op_n     = opcode[3:0];
  assign op_nn    = opcode[7:0];
  assign op_nnn   = opcode[11:0];

`ifdef OPCODE_FETCH_ILLEGAL_TRAP_EN
  logic illegal_enc;

  always_comb begin
    illegal_enc = 1'b0;
    case (opcode[15:12])
      4'h0:       illegal_enc = (opcode[11:8] != 4'h0) || (opcode[7:4] != 4'hE) ||
                                ((opcode[3:0] != 4'h0) && (opcode[3:0] != 4'hE));
      4'h5, 4'h9: illegal_enc = (opcode[3:0] != 4'h0);
      4'h8:       illegal_enc = opcode[3] && (opcode[3:0] != 4'hE);
      4'hE:       illegal_enc = (opcode[7:0] != 8'h9E) && (opcode[7:0] != 8'hA1);
      4'hF: begin
        case (opcode[7:0])
          8'h07, 8'h0A, 8'h15, 8'h18, 8'h1E, 8'h29, 8'h33, 8'h55, 8'h65: illegal_enc = 1'b0;
          default: illegal_enc = 1'b1;
        endcase
      end
      default:    illegal_enc = 1'b0;
    endcase
  end

  assign op_illegal = op_valid && illegal_enc;
`else
  assign op_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_opcode_fetch.sv
// Self-checking bench for opcode_fetch: directed vector table, flush/reset sequences, randomized run vs. a byte-memory model.
module tb_opcode_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] program_counter;
  logic        flush;
  logic        mem_gnt;
  logic [7:0]  mem_rdata;
  logic [11:0] mem_addr;
  logic        mem_re;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] opcode;
  logic [15:0] op_pc;
  logic [3:0]  op_class, op_x, op_y, op_n;
  logic [7:0]  op_nn;
  logic [11:0] op_nnn;
  logic        op_illegal;
  logic        stalled;

`ifdef OPCODE_FETCH_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  opcode_fetch dut (
    .clk(clk), .rst(rst), .program_counter(program_counter), .flush(flush),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_re(mem_re),
    .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode), .op_pc(op_pc),
    .op_class(op_class), .op_x(op_x), .op_y(op_y), .op_n(op_n), .op_nn(op_nn),
    .op_nnn(op_nnn), .op_illegal(op_illegal), .stalled(stalled)
  );

  always #5 clk = ~clk;

  // Byte memory with one-cycle read latency; unaccepted cycles return junk.
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_re && mem_gnt) mem_rdata <= mem[mem_addr];
    else                   mem_rdata <= 8'($urandom);
  end

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          gnt_low;
    int          ready_low;
    logic [15:0] exp_op;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [8];
  int   checks = 0;
  int   errors = 0;

  function automatic logic is_illegal(input logic [15:0] op);
    case (op[15:12])
      4'h0:       return !(op == 16'h00E0 || op == 16'h00EE);
      4'h5, 4'h9: return op[3:0] != 4'h0;
      4'h8:       return op[3:0] inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF};
      4'hE:       return !(op[7:0] inside {8'h9E, 8'hA1});
      4'hF:       return !(op[7:0] inside {8'h07, 8'h0A, 8'h15, 8'h18, 8'h1E, 8'h29, 8'h33, 8'h55, 8'h65});
      default:    return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkOpcode(input logic [15:0] exp, input logic [15:0] pc, input logic ill);
    checkOutput("opcode", 32'(opcode), 32'(exp));
    checkOutput("op_pc", 32'(op_pc), 32'(pc));
    checkOutput("op_class", 32'(op_class), 32'(exp[15:12]));
    checkOutput("op_x", 32'(op_x), 32'(exp[11:8]));
    checkOutput("op_y", 32'(op_y), 32'(exp[7:4]));
    checkOutput("op_n", 32'(op_n), 32'(exp[3:0]));
    checkOutput("op_nn", 32'(op_nn), 32'(exp[7:0]));
    checkOutput("op_nnn", 32'(op_nnn), 32'(exp[11:0]));
    checkOutput("op_illegal", 32'(op_illegal), 32'(TRAP_EN ? ill : 1'b0));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic loadOpcode(input logic [15:0] pc, input logic [7:0] hi, input logic [7:0] lo);
    logic [11:0] a;
    a = pc[11:0];
    mem[a] = hi;
    a = a + 12'd1;
    mem[a] = lo;
  endtask

  // Entered just after the edge that starts an HI_REQ cycle; leaves at the next HI_REQ cycle.
  task automatic applyStimulus(input vec_t v);
    logic [11:0] a2;
    a2 = v.pc[11:0] + 12'd1;
    loadOpcode(v.pc, v.hi, v.lo);
    program_counter = v.pc;
    mem_gnt = 1'b1;
    op_ready = 1'b0;
    flush = 1'b0;
    sample();
    checkOutput("hi_re", 32'(mem_re), 32'd1);
    checkOutput("hi_addr", 32'(mem_addr), 32'(v.pc[11:0]));
    checkOutput("hi_valid", 32'(op_valid), 32'd0);
    checkOutput("hi_stalled", 32'(stalled), 32'd1);
    for (int i = 0; i < v.gnt_low; i++) begin
      nextCycle();
      mem_gnt = 1'b0;
      sample();
      checkOutput("lo_stall_re", 32'(mem_re), 32'd0);
      checkOutput("lo_stall_valid", 32'(op_valid), 32'd0);
    end
    nextCycle();
    mem_gnt = 1'b1;
    sample();
    checkOutput("lo_re", 32'(mem_re), 32'd1);
    checkOutput("lo_addr", 32'(mem_addr), 32'(a2));
    nextCycle();
    sample();
    checkOutput("wait_valid", 32'(op_valid), 32'd0);
    checkOutput("wait_re", 32'(mem_re), 32'd0);
    for (int i = 0; i < v.ready_low; i++) begin
      nextCycle();
      sample();
      checkOutput("hold_valid", 32'(op_valid), 32'd1);
      checkOutput("hold_stalled", 32'(stalled), 32'd1);
      checkOutput("hold_re", 32'(mem_re), 32'd0);
      checkOutput("hold_opcode", 32'(opcode), 32'(v.exp_op));
    end
    nextCycle();
    op_ready = 1'b1;
    sample();
    checkOutput("valid", 32'(op_valid), 32'd1);
    checkOutput("valid_stalled", 32'(stalled), 32'd0);
    checkOpcode(v.exp_op, v.pc, v.exp_ill);
    nextCycle();
    op_ready = 1'b0;
  endtask

  task automatic runFetch(input logic [15:0] exp, input logic [15:0] pc);
    nextCycle();
    nextCycle();
    nextCycle();
    sample();
    checkOutput("fetch_valid", 32'(op_valid), 32'd1);
    checkOpcode(exp, pc, is_illegal(exp));
    nextCycle();
  endtask

  initial begin
    vecs[0] = '{16'hA070, 8'h12, 8'h34, 0, 0, 16'h1234, 1'b0};
    vecs[1] = '{16'h0FFF, 8'h6A, 8'h05, 0, 0, 16'h6A05, 1'b0};
    vecs[2] = '{16'h0200, 8'hD1, 8'h25, 3, 0, 16'hD125, 1'b0};
    vecs[3] = '{16'h0202, 8'hA2, 8'hF0, 0, 5, 16'hA2F0, 1'b0};
    vecs[4] = '{16'h0301, 8'h51, 8'h21, 1, 2, 16'h5121, 1'b1};
    vecs[5] = '{16'h0400, 8'hF0, 8'hFF, 0, 0, 16'hF0FF, 1'b1};
    vecs[6] = '{16'h0402, 8'h00, 8'hEE, 0, 1, 16'h00EE, 1'b0};
    vecs[7] = '{16'h00A1, 8'h81, 8'h2F, 2, 0, 16'h812F, 1'b1};

    rst = 1'b1;
    flush = 1'b0;
    mem_gnt = 1'b1;
    op_ready = 1'b0;
    program_counter = 16'h0000;
    repeat (3) @(posedge clk);
    sample();
    checkOutput("rst_valid", 32'(op_valid), 32'd0);
    checkOutput("rst_opcode", 32'(opcode), 32'd0);
    checkOutput("rst_op_pc", 32'(op_pc), 32'd0);
    checkOutput("rst_illegal", 32'(op_illegal), 32'd0);
    checkOutput("rst_stalled", 32'(stalled), 32'd1);
    checkOutput("rst_re", 32'(mem_re), 32'd0);
    nextCycle();
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Flush in LO_WAIT, then refetch from the redirected PC.
    loadOpcode(16'h0500, 8'h3A, 8'h11);
    loadOpcode(16'h0600, 8'h7B, 8'h22);
    program_counter = 16'h0500;
    op_ready = 1'b1;
    nextCycle();
    nextCycle();
    flush = 1'b1;
    sample();
    checkOutput("flw_valid", 32'(op_valid), 32'd0);
    nextCycle();
    flush = 1'b0;
    program_counter = 16'h0600;
    sample();
    checkOutput("flw_next_valid", 32'(op_valid), 32'd0);
    checkOutput("flw_next_re", 32'(mem_re), 32'd1);
    checkOutput("flw_next_addr", 32'(mem_addr), 32'h600);
    runFetch(16'h7B22, 16'h0600);

    // Flush together with a handshake in VALID.
    loadOpcode(16'h0610, 8'hC3, 8'h0F);
    loadOpcode(16'h0620, 8'h44, 8'h55);
    program_counter = 16'h0610;
    nextCycle();
    nextCycle();
    nextCycle();
    flush = 1'b1;
    sample();
    checkOutput("flv_valid", 32'(op_valid), 32'd1);
    checkOutput("flv_stalled", 32'(stalled), 32'd0);
    checkOutput("flv_opcode", 32'(opcode), 32'hC30F);
    nextCycle();
    flush = 1'b0;
    program_counter = 16'h0620;
    sample();
    checkOutput("flv_next_valid", 32'(op_valid), 32'd0);
    checkOutput("flv_next_addr", 32'(mem_addr), 32'h620);
    checkOutput("flv_next_re", 32'(mem_re), 32'd1);
    runFetch(16'h4455, 16'h0620);

    // Asynchronous reset while in LO_REQ.
    loadOpcode(16'h0700, 8'h99, 8'h90);
    program_counter = 16'h0700;
    nextCycle();
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(op_valid), 32'd0);
    checkOutput("arst_opcode", 32'(opcode), 32'd0);
    checkOutput("arst_op_pc", 32'(op_pc), 32'd0);
    checkOutput("arst_illegal", 32'(op_illegal), 32'd0);
    checkOutput("arst_stalled", 32'(stalled), 32'd1);
    checkOutput("arst_re", 32'(mem_re), 32'd0);
    nextCycle();
    rst = 1'b0;
    sample();
    checkOutput("arst_hi_addr", 32'(mem_addr), 32'h700);
    runFetch(16'h9990, 16'h0700);

    // Randomized run: every consumed opcode must equal the two bytes at the PC it was fetched from.
    begin
      int  done = 0;
      int  idle = 0;
      bit  advance = 1'b0;
      logic [15:0] exp;
      logic [11:0] a;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      program_counter = 16'($urandom);
      for (int cyc = 0; cyc < 1500; cyc++) begin
        nextCycle();
        if (advance) program_counter = 16'($urandom);
        advance = 1'b0;
        mem_gnt  = ($urandom_range(0, 3) != 0);
        op_ready = ($urandom_range(0, 2) != 0);
        flush    = ($urandom_range(0, 29) == 0);
        sample();
        if (op_valid) checkOutput("rand_re_in_valid", 32'(mem_re), 32'd0);
        if (flush) begin
          advance = 1'b1;
        end else if (op_valid && op_ready) begin
          a = program_counter[11:0];
          exp[15:8] = mem[a];
          a = a + 12'd1;
          exp[7:0] = mem[a];
          checkOpcode(exp, program_counter, is_illegal(exp));
          done++;
          idle = 0;
          advance = 1'b1;
        end
        idle++;
        if (idle > 150) begin
          checkOutput("rand_timeout", 32'(idle), 32'd0);
          break;
        end
      end
      flush = 1'b0;
      checkOutput("rand_progress", 32'(done > 50), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opcode_fetch.md
# opcode_fetch

Fetches the 16-bit big-endian CHIP-8 opcode at the current program counter over an 8-bit synchronous memory port, decodes its fields, and presents it to execute with a valid/ready handshake. Sits between the PC stage, whose `program_counter` it consumes and whose `stalled` input it drives, and the execute stage. Owns the memory read port only when arbitration grants it.

## Interface
- Parameters: none.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `program_counter`  in  16  byte address from the PC stage; bits [15:12] ignored.
- `flush`  in  1  execute redirects PC this cycle; in-flight opcode discarded.
- `mem_gnt`  in  1  memory port granted to this block this cycle.
- `mem_rdata`  in  8  read data, valid exactly one cycle after an accepted read.
- `mem_addr`  out  12  read address.
- `mem_re`  out  1  read request; accepted when `mem_re && mem_gnt`.
- `op_valid`  out  1  opcode and fields valid.
- `op_ready`  in  1  execute accepts the opcode.
- `opcode`  out  16  {high byte, low byte}.
- `op_pc`  out  16  `program_counter` value the opcode was fetched from.
- `op_class`, `op_x`, `op_y`, `op_n`  out  4 each  opcode[15:12], [11:8], [7:4], [3:0].
- `op_nn`  out  8  opcode[7:0]; `op_nnn` out 12 opcode[11:0].
- `op_illegal`  out  1  see Configuration.
- `stalled`  out  1  to PC stage: `!(op_valid && op_ready)`.

## Operation
- States: HI_REQ, LO_REQ, LO_WAIT, VALID. Reset state HI_REQ.
- HI_REQ: `mem_addr = program_counter[11:0]`, `mem_re = mem_gnt`; on accept → LO_REQ, latch `op_pc`.
- LO_REQ: high byte captured from `mem_rdata` on the first cycle after the HI accept (held internally regardless of `mem_gnt`); `mem_addr = op_pc[11:0] + 1` (12-bit wrap, 0xFFF → 0x000), `mem_re = mem_gnt`; on accept → LO_WAIT.
- LO_WAIT: low byte captured, `opcode` updated → VALID.
- VALID: `op_valid = 1`, `opcode`/fields stable; on `op_ready` → HI_REQ.
- `mem_re` low in LO_WAIT and VALID; `mem_gnt` low stalls HI_REQ/LO_REQ without losing captured data.
- `flush` in any state: next state HI_REQ, `op_valid` deasserts next cycle, pending read data ignored; `flush` overrides a simultaneous handshake (no opcode counted as consumed by this block). `stalled` still follows its equation.
- Odd PC legal; no alignment enforced.
- Fields are combinational slices of the `opcode` register.

## Timing
- Reset values: state HI_REQ, `op_valid` 0, `opcode` 0, `op_pc` 0, `op_illegal` 0, `stalled` 1, `mem_re` 0 while `rst` held.
- With `mem_gnt` held high: HI accept t0, LO accept t1, capture t2, `op_valid` from t3. Accept at t3 → PC advances at t3 edge → HI_REQ reads new PC at t4. Throughput: one opcode per 4 cycles.
- Each `mem_gnt`-low cycle in HI_REQ/LO_REQ adds one cycle.
- `stalled` is combinational from `op_valid` and `op_ready`.
- Reset mid-fetch: immediate return to reset values; no partial opcode ever reaches `op_valid`.

## Configuration
- `OPCODE_FETCH_ILLEGAL_TRAP_EN` defined: `op_illegal` = 1 with `op_valid` for illegal encodings: 0NNN other than 00E0/00EE; 5XYn/9XYn with n≠0; 8XYn with n ∈ {8..D, F}; EXnn with nn ∉ {9E, A1}; FXnn with nn ∉ {07, 0A, 15, 18, 1E, 29, 33, 55, 65}.
- Undefined: `op_illegal` tied to 0, no decode logic.

## Test plan
- PC=0x070, mem[0x70]=0x12, mem[0x71]=0x34, gnt=1, ready=1 → `op_valid` at t3, `opcode`=0x1234, `op_nnn`=0x234, `stalled`=0 at t3 only.
- PC=0xFFF, mem[0xFFF]=0x6A, mem[0x000]=0x05 → second `mem_addr`=0x000, `opcode`=0x6A05, `op_x`=0xA, `op_nn`=0x05.
- `mem_gnt` low 3 cycles in LO_REQ → `opcode` unchanged-correct (0xD125), `op_valid` 3 cycles late, high byte not lost.
- `op_ready` low 5 cycles in VALID → `opcode` stable, `stalled`=1, no `mem_re`; ready high → next fetch starts following cycle.
- `flush` asserted in LO_WAIT and with `op_valid && op_ready` → `op_valid` 0 next cycle, HI_REQ reads new PC; async `rst` in LO_REQ → all outputs reset values.
- With macro: 0x5121 and 0xF0FF → `op_illegal`=1; 0x00EE → 0. Without macro: always 0.
